// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage -- instruction-fetch stage of the CPU pipeline
// ----------------------------------------------------------------------------
// Holds the program counter and drives a synchronous-read instruction memory.
// The word returned by the memory always belongs to the registered PC, so the
// decode outputs are plain slices of imem_rdata qualified by valid_q. Jumps
// resolved in execute redirect the PC and squash the wrong-path instruction
// currently in decode (one bubble). A stall from the hazard logic holds the
// PC, which re-reads the same word and keeps every id_* output stable.
//
// Optional feature (macro FETCH_PERF_EN):
//   defined   -> perf_fetch / perf_flush are saturating 32-bit counters
//   undefined -> both ports are tied to zero, no counter logic is built
//
// Parameters:
//   AW        PC / instruction-memory word-address width
//   RESET_PC  PC value loaded on reset
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   rst          in   asynchronous active-low reset
//   stall        in   hold PC and decode outputs
//   ex_valid     in   execute stage holds a real instruction
//   ex_wpc       in   execute instruction is a jump
//   ex_jmpF      in   jump condition (00 always, 01 zero, 10 not zero, 11 neg)
//   ex_zero      in   ALU zero flag of the execute instruction
//   ex_neg       in   ALU negative flag of the execute instruction
//   ex_target    in   jump target word address
//   imem_addr    out  instruction-memory read address (next PC)
//   imem_rdata   in   memory data for the address of the previous cycle
//   id_valid     out  decode outputs hold a real instruction
//   id_pc        out  address of the presented instruction
//   id_op        out  instruction bits [31:30]
//   id_inst      out  instruction bits [29:28]
//   id_immin     out  instruction bit  [27]
//   id_rd        out  instruction bits [26:23]
//   id_rs1       out  instruction bits [22:19]
//   id_rs2       out  instruction bits [18:15]
//   id_imm       out  instruction bits [14:0]
//   redirect     out  taken jump this cycle
//   perf_fetch   out  count of instructions accepted by decode
//   perf_flush   out  count of redirects
// ============================================================================
module fetch_stage #(
  parameter int            AW       = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          ex_valid,
  input  logic          ex_wpc,
  input  logic [1:0]    ex_jmpF,
  input  logic          ex_zero,
  input  logic          ex_neg,
  input  logic [AW-1:0] ex_target,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  output logic [AW-1:0] id_pc,
  output logic [1:0]    id_op,
  output logic [1:0]    id_inst,
  output logic          id_immin,
  output logic [3:0]    id_rd,
  output logic [3:0]    id_rs1,
  output logic [3:0]    id_rs2,
  output logic [14:0]   id_imm,
  output logic          redirect,
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_flush
);

  // Jump-condition encoding shared with the control unit's jmpF field.
  typedef enum logic [1:0] {
    JMP_ALWAYS = 2'b00,
    JMP_ZERO   = 2'b01,
    JMP_NZERO  = 2'b10,
    JMP_NEG    = 2'b11
  } jmp_cond_e;

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic          valid_q;
  logic          cond;
  logic          taken;

  // --------------------------------------------------------------------------
  // Jump resolution
  // --------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cond = 1'b0;
    case (jmp_cond_e'(ex_jmpF))
      JMP_ALWAYS: cond = 1'b1;
      JMP_ZERO:   cond = ex_zero;
      JMP_NZERO:  cond = ~ex_zero;
      JMP_NEG:    cond = ex_neg;
      default:    cond = 1'b0;
    endcase
  end

  assign taken    = ex_valid & ex_wpc & cond;
  assign redirect = taken;

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  // Until the first edge after reset (valid_q = 0) the PC holds at RESET_PC
  // and that address is presented to the memory, so the RESET_PC word is
  // already in imem_rdata when valid_q rises. After that the invariant is:
  // imem_rdata is always the word at pc_q.
  always_comb begin
    pc_d = pc_q;
    if (!valid_q) begin
      pc_d = RESET_PC;
    end else if (taken) begin
      pc_d = ex_target;
    end else if (!stall) begin
      pc_d = pc_q + AW'(1);  // wraps modulo 2^AW
    end
  end

  assign imem_addr = pc_d;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Decode outputs
  // --------------------------------------------------------------------------
  // A taken jump squashes whatever sits in decode: it is the wrong-path
  // instruction fetched behind the jump.
  assign id_valid = valid_q & ~taken;
  assign id_pc    = pc_q;
  assign id_op    = imem_rdata[31:30];
  assign id_inst  = imem_rdata[29:28];
  assign id_immin = imem_rdata[27];
  assign id_rd    = imem_rdata[26:23];
  assign id_rs1   = imem_rdata[22:19];
  assign id_rs2   = imem_rdata[18:15];
  assign id_imm   = imem_rdata[14:0];

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;

  // An instruction counts as fetched on the edge where decode accepts it:
  // valid, not squashed and not held by a stall. Both counters saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (id_valid && !stall && !(&perf_fetch_q)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (taken && !(&perf_flush_q)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_fetch = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage -- directed self-checking bench for fetch_stage
// ----------------------------------------------------------------------------
// Two instances: dut_a (AW=10, RESET_PC=0) carries the directed sequence,
// dut_b (AW=4, RESET_PC=14) free-runs to show PC wrap-around. Each has a
// synchronous-read memory model whose contents are a fixed hash of the
// address, so expected fields follow from the expected PC alone.
// ============================================================================
module tb_fetch_stage;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef FETCH_PERF_EN
  localparam logic [31:0] EXP_FETCH = 32'd10;
  localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
  localparam logic [31:0] EXP_FETCH = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       ex_valid;
  logic       ex_wpc;
  logic [1:0] ex_jmpF;
  logic       ex_zero;
  logic       ex_neg;
  logic [9:0] ex_target;

  initial forever #20 clk = ~clk;

  // Memory contents: word at address a.
  function automatic logic [31:0] word(input logic [9:0] a);
    return (32'h9E37_79B9 * {22'd0, a}) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- dut_a ----------------
  logic [9:0]  a_imem_addr;
  logic [31:0] a_imem_rdata;
  logic        a_id_valid;
  logic [9:0]  a_id_pc;
  logic [1:0]  a_id_op, a_id_inst;
  logic        a_id_immin;
  logic [3:0]  a_id_rd, a_id_rs1, a_id_rs2;
  logic [14:0] a_id_imm;
  logic        a_redirect;
  logic [31:0] a_perf_fetch, a_perf_flush;

  fetch_stage #(.AW(10), .RESET_PC(10'd0)) dut_a (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_wpc(ex_wpc), .ex_jmpF(ex_jmpF),
    .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_target(ex_target),
    .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
    .id_valid(a_id_valid), .id_pc(a_id_pc), .id_op(a_id_op),
    .id_inst(a_id_inst), .id_immin(a_id_immin), .id_rd(a_id_rd),
    .id_rs1(a_id_rs1), .id_rs2(a_id_rs2), .id_imm(a_id_imm),
    .redirect(a_redirect), .perf_fetch(a_perf_fetch), .perf_flush(a_perf_flush)
  );

  always @(posedge clk) a_imem_rdata <= word(a_imem_addr);

  // ---------------- dut_b ----------------
  logic [3:0]  b_imem_addr;
  logic [31:0] b_imem_rdata;
  logic        b_id_valid;
  logic [3:0]  b_id_pc;
  logic [1:0]  b_id_op, b_id_inst;
  logic        b_id_immin;
  logic [3:0]  b_id_rd, b_id_rs1, b_id_rs2;
  logic [14:0] b_id_imm;
  logic        b_redirect;
  logic [31:0] b_perf_fetch, b_perf_flush;

  fetch_stage #(.AW(4), .RESET_PC(4'd14)) dut_b (
    .clk(clk), .rst(rst), .stall(1'b0),
    .ex_valid(1'b0), .ex_wpc(1'b0), .ex_jmpF(2'b00),
    .ex_zero(1'b0), .ex_neg(1'b0), .ex_target(4'd0),
    .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
    .id_valid(b_id_valid), .id_pc(b_id_pc), .id_op(b_id_op),
    .id_inst(b_id_inst), .id_immin(b_id_immin), .id_rd(b_id_rd),
    .id_rs1(b_id_rs1), .id_rs2(b_id_rs2), .id_imm(b_id_imm),
    .redirect(b_redirect), .perf_fetch(b_perf_fetch), .perf_flush(b_perf_flush)
  );

  always @(posedge clk) b_imem_rdata <= word({6'd0, b_imem_addr});

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction presented by dut_a: valid, at pc, fields matching word(pc).
  task automatic check_a(input string tag, input logic [9:0] pc);
    check({tag, " id_valid"}, {31'd0, a_id_valid}, 32'd1);
    check({tag, " id_pc"}, {22'd0, a_id_pc}, {22'd0, pc});
    check({tag, " fields"},
          {a_id_op, a_id_inst, a_id_immin, a_id_rd, a_id_rs1, a_id_rs2, a_id_imm},
          word(pc));
  endtask

  task automatic check_b(input string tag, input logic [3:0] pc);
    check({tag, " b id_pc"}, {28'd0, b_id_pc}, {28'd0, pc});
    check({tag, " b fields"},
          {b_id_op, b_id_inst, b_id_immin, b_id_rd, b_id_rs1, b_id_rs2, b_id_imm},
          word({6'd0, pc}));
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] b_seq [4];

  initial begin
    b_seq[0] = 4'd14; b_seq[1] = 4'd15; b_seq[2] = 4'd0; b_seq[3] = 4'd1;
    rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_wpc = 1'b0;
    ex_jmpF = 2'b00; ex_zero = 1'b0; ex_neg = 1'b0; ex_target = '0;

    // ---- reset state ----
    tick();
    check("rst id_valid", {31'd0, a_id_valid}, 32'd0);
    check("rst redirect", {31'd0, a_redirect}, 32'd0);
    check("rst id_pc", {22'd0, a_id_pc}, 32'd0);
    check("rst imem_addr", {22'd0, a_imem_addr}, 32'd0);
    check("rst b imem_addr", {28'd0, b_imem_addr}, 32'd14);
    check("rst perf_fetch", a_perf_fetch, 32'd0);
    check("rst perf_flush", a_perf_flush, 32'd0);

    // ---- release: RESET_PC held one cycle, then sequential fetch ----
    rst = 1'b1;
    #1;
    check("release id_valid", {31'd0, a_id_valid}, 32'd0);
    check("release imem_addr", {22'd0, a_imem_addr}, 32'd0);
    tick();
    check_a("seq0", 10'd0);
    check("seq0 imem_addr", {22'd0, a_imem_addr}, 32'd1);
    check_b("seq0", b_seq[0]);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_a("seq", 10'(i));
      check_b("seq", b_seq[i]);
    end

    // ---- unconditional jump to 0x40 ----
    ex_valid = 1'b1; ex_wpc = 1'b1; ex_jmpF = 2'b00; ex_target = 10'h40;
    #1;
    check("jmp00 redirect", {31'd0, a_redirect}, 32'd1);
    check("jmp00 squash", {31'd0, a_id_valid}, 32'd0);
    check("jmp00 imem_addr", {22'd0, a_imem_addr}, 32'h40);
    tick();
    ex_valid = 1'b0;
    #1;
    check_a("jmp00 target", 10'h40);
    check("jmp00 after redirect", {31'd0, a_redirect}, 32'd0);

    // ---- jmpF=01: zero=0 not taken, zero=1 taken ----
    ex_valid = 1'b1; ex_wpc = 1'b1; ex_jmpF = 2'b01; ex_zero = 1'b0; ex_target = 10'h80;
    #1;
    check("jmp01 z0 redirect", {31'd0, a_redirect}, 32'd0);
    check("jmp01 z0 id_valid", {31'd0, a_id_valid}, 32'd1);
    check("jmp01 z0 imem_addr", {22'd0, a_imem_addr}, 32'h41);
    tick();
    check_a("jmp01 z0 seq", 10'h41);
    ex_zero = 1'b1;
    #1;
    check("jmp01 z1 redirect", {31'd0, a_redirect}, 32'd1);
    check("jmp01 z1 squash", {31'd0, a_id_valid}, 32'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    check_a("jmp01 target", 10'h80);

    // ---- remaining conditions and qualifiers (combinational) ----
    ex_valid = 1'b1; ex_wpc = 1'b1; ex_jmpF = 2'b10; ex_zero = 1'b1; ex_neg = 1'b0;
    #1; check("jmp10 z1", {31'd0, a_redirect}, 32'd0);
    ex_zero = 1'b0;
    #1; check("jmp10 z0", {31'd0, a_redirect}, 32'd1);
    ex_jmpF = 2'b11;
    #1; check("jmp11 n0", {31'd0, a_redirect}, 32'd0);
    ex_neg = 1'b1;
    #1; check("jmp11 n1", {31'd0, a_redirect}, 32'd1);
    ex_wpc = 1'b0;
    #1; check("no wpc", {31'd0, a_redirect}, 32'd0);
    ex_wpc = 1'b1; ex_valid = 1'b0;
    #1; check("no ex_valid", {31'd0, a_redirect}, 32'd0);

    // ---- jump to 5, then stall 3 cycles ----
    ex_valid = 1'b1; ex_jmpF = 2'b00; ex_neg = 1'b0; ex_target = 10'd5;
    tick();
    ex_valid = 1'b0;
    #1;
    check_a("to5", 10'd5);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a("stall", 10'd5);
      check("stall imem_addr", {22'd0, a_imem_addr}, 32'd5);
    end

    // ---- taken jump during stall wins ----
    ex_valid = 1'b1; ex_wpc = 1'b1; ex_jmpF = 2'b00; ex_target = 10'h10;
    #1;
    check("stall+jmp redirect", {31'd0, a_redirect}, 32'd1);
    check("stall+jmp imem_addr", {22'd0, a_imem_addr}, 32'h10);
    tick();
    ex_valid = 1'b0; stall = 1'b0;
    #1;
    check_a("stall+jmp target", 10'h10);
    tick();
    check_a("stall+jmp next", 10'h11);

    // ---- async reset mid-cycle ----
    rst = 1'b0;
    #1;
    check("async rst id_valid", {31'd0, a_id_valid}, 32'd0);
    check("async rst id_pc", {22'd0, a_id_pc}, 32'd0);
    check("async rst b id_pc", {28'd0, b_id_pc}, 32'd14);

    // ---- perf: 10 sequential fetches + 2 taken jumps ----
    tick();
    rst = 1'b1;
    tick();
    check_a("perf seq0", 10'd0);
    for (int i = 1; i <= 10; i++) tick();
    check_a("perf seq10", 10'd10);
    check("perf_fetch after seq", a_perf_fetch, EXP_FETCH);
    ex_valid = 1'b1; ex_wpc = 1'b1; ex_jmpF = 2'b00; ex_target = 10'h20;
    tick();
    ex_target = 10'h30;
    #1;
    check("back-to-back squash", {31'd0, a_id_valid}, 32'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    check_a("perf target", 10'h30);
    check("perf_fetch", a_perf_fetch, EXP_FETCH);
    check("perf_flush", a_perf_flush, EXP_FLUSH);

    rst = 1'b0;
    #1;
    check("perf rst fetch", a_perf_fetch, 32'd0);
    check("perf rst flush", a_perf_flush, 32'd0);
    check("perf rst id_valid", {31'd0, a_id_valid}, 32'd0);
    tick();
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
